// File: rtl/vram_write_arbiter_pkg.sv
// Shared definitions for the video RAM write arbiter: default widths and the
// rectangle-fill engine state encoding.
package vram_write_arbiter_pkg;

    localparam int X_W_DEF     = 8;
    localparam int Y_W_DEF     = 8;
    localparam int COLOR_W_DEF = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DONE = 2'd2
    } fill_state_e;

endpackage

// File: rtl/vram_write_arbiter_fill_scan_counter.sv
// Row-major 2-D scan counter for the fill engine: cx walks 0..W-1, then wraps
// and bumps cy; last_o flags the final pixel of the rectangle.
module fill_scan_counter
    import vram_write_arbiter_pkg::*;
#(
    parameter int X_W = X_W_DEF,
    parameter int Y_W = Y_W_DEF
) (
    input  logic           Clock,
    input  logic           Reset,
    input  logic           clear_i,
    input  logic           enable_i,
    input  logic [X_W-1:0] width_i,
    input  logic [Y_W-1:0] height_i,
    output logic [X_W-1:0] cx_o,
    output logic [Y_W-1:0] cy_o,
    output logic           last_o
);

    localparam logic [X_W-1:0] X_ONE = X_W'(1);
    localparam logic [Y_W-1:0] Y_ONE = Y_W'(1);

    logic [X_W-1:0] cx_q, cx_d;
    logic [Y_W-1:0] cy_q, cy_d;
    logic           rowEnd;

    assign rowEnd = (cx_q == (width_i - X_ONE));
    assign last_o = rowEnd && (cy_q == (height_i - Y_ONE));
    assign cx_o   = cx_q;
    assign cy_o   = cy_q;

    always_comb begin
        cx_d = cx_q;
        cy_d = cy_q;
        if (clear_i) begin
            cx_d = '0;
            cy_d = '0;
        end else if (enable_i) begin
            if (rowEnd) begin
                cx_d = '0;
                cy_d = cy_q + Y_ONE;
            end else begin
                cx_d = cx_q + X_ONE;
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            cx_q <= '0;
            cy_q <= '0;
        end else begin
            cx_q <= cx_d;
            cy_q <= cy_d;
        end
    end

endmodule

// File: rtl/vram_write_arbiter.sv
// Owns the single video RAM write port: the CPU pixel path always wins, and the
// rectangle-fill engine uses every cycle the CPU leaves free.
module vram_write_arbiter
    import vram_write_arbiter_pkg::*;
#(
    parameter int X_W     = X_W_DEF,
    parameter int Y_W     = Y_W_DEF,
    parameter int COLOR_W = COLOR_W_DEF
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               iCpuWrReq,
    input  logic [X_W-1:0]     iCpuX,
    input  logic [Y_W-1:0]     iCpuY,
    input  logic [COLOR_W-1:0] iCpuColor,
    input  logic               iFillStart,
    input  logic               iFillAbort,
    input  logic [X_W-1:0]     iFillX0,
    input  logic [Y_W-1:0]     iFillY0,
    input  logic [X_W-1:0]     iFillW,
    input  logic [Y_W-1:0]     iFillH,
    input  logic [COLOR_W-1:0] iFillColor,
    output logic               oFillBusy,
    output logic               oFillDone,
    output logic               oWrEn,
    output logic [X_W+Y_W-1:0] oWrAddr,
    output logic [COLOR_W-1:0] oWrData
);

    fill_state_e state_q, state_d;

    logic [X_W-1:0]     x0_q, x0_d, w_q, w_d;
    logic [Y_W-1:0]     y0_q, y0_d, h_q, h_d;
    logic [COLOR_W-1:0] color_q, color_d;

    logic               wrEn_q, wrEn_d;
    logic [X_W+Y_W-1:0] wrAddr_q, wrAddr_d;
    logic [COLOR_W-1:0] wrData_q, wrData_d;
    logic               done_q, done_d;

    logic               startAccept;
    logic               fillGrant;
    logic [X_W-1:0]     cx, fillX;
    logic [Y_W-1:0]     cy, fillY;
    logic               scanLast;

    assign startAccept = (state_q == ST_IDLE) && iFillStart && !iFillAbort;
    assign fillGrant   = (state_q == ST_FILL) && !iCpuWrReq && !iFillAbort;
    assign fillX       = x0_q + cx;
    assign fillY       = y0_q + cy;

    fill_scan_counter #(
        .X_W (X_W),
        .Y_W (Y_W)
    ) u_scan (
        .Clock    (Clock),
        .Reset    (Reset),
        .clear_i  (startAccept),
        .enable_i (fillGrant),
        .width_i  (w_q),
        .height_i (h_q),
        .cx_o     (cx),
        .cy_o     (cy),
        .last_o   (scanLast)
    );

    // Fill FSM plus rectangle latching; an abort always wins over a start
    always_comb begin
        state_d = state_q;
        x0_d    = x0_q;
        y0_d    = y0_q;
        w_d     = w_q;
        h_d     = h_q;
        color_d = color_q;
        unique case (state_q)
            ST_IDLE: begin
                if (startAccept) begin
                    x0_d    = iFillX0;
                    y0_d    = iFillY0;
                    w_d     = iFillW;
                    h_d     = iFillH;
                    color_d = iFillColor;
                    state_d = ((iFillW == '0) || (iFillH == '0)) ? ST_DONE : ST_FILL;
                end
            end
            ST_FILL: begin
                if (iFillAbort) begin
                    state_d = ST_IDLE;
                end else if (fillGrant && scanLast) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        wrEn_d   = 1'b0;
        wrAddr_d = wrAddr_q;
        wrData_d = wrData_q;
        if (iCpuWrReq) begin
            wrEn_d   = 1'b1;
            wrAddr_d = {iCpuX, iCpuY};
            wrData_d = iCpuColor;
        end else if (fillGrant) begin
            wrEn_d   = 1'b1;
            wrAddr_d = {fillX, fillY};
            wrData_d = color_q;
        end
        done_d = (state_q == ST_DONE) && !iFillAbort;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q  <= ST_IDLE;
            x0_q     <= '0;
            y0_q     <= '0;
            w_q      <= '0;
            h_q      <= '0;
            color_q  <= '0;
            wrEn_q   <= 1'b0;
            wrAddr_q <= '0;
            wrData_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            x0_q     <= x0_d;
            y0_q     <= y0_d;
            w_q      <= w_d;
            h_q      <= h_d;
            color_q  <= color_d;
            wrEn_q   <= wrEn_d;
            wrAddr_q <= wrAddr_d;
            wrData_q <= wrData_d;
            done_q   <= done_d;
        end
    end

    assign oFillBusy = (state_q == ST_FILL) || (state_q == ST_DONE);
    assign oFillDone = done_q;
    assign oWrEn     = wrEn_q;
    assign oWrAddr   = wrAddr_q;
    assign oWrData   = wrData_q;

endmodule
